// File: rtl/down_count_seq_checker.sv
// down_count_seq_checker: monitors a MOD-N down counter, flags illegal successors,
// counts reloads and violations, and reports when the sequence is locked.
module down_count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int MOD_MAX  = 15,
  parameter int CNT_W    = 8,
  parameter int LOCK_RUN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             clear_err,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] wrap_count,
  output logic             seq_err,
  output logic [CNT_W-1:0] err_count,
  output logic             locked
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD_MAX);
  typedef enum logic [1:0] {EMPTY, ACQUIRE, LOCKED} state_t;
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev, w_prev_nxt, w_exp;
  logic [RW-1:0]    r_run, w_run_nxt, w_run_inc;
  logic             r_wrap, w_wrap_nxt, r_err, w_err_nxt, w_legal, w_reload;
  logic [CNT_W-1:0] r_wcnt, w_wcnt_nxt, r_ecnt, w_ecnt_nxt, w_ecnt_base;
  always_comb begin
    w_exp       = (r_prev == '0) ? MAXV : r_prev - 1'b1;
    w_legal     = (count_in == w_exp) && (count_in <= MAXV);
    w_reload    = w_legal && (r_prev == '0);
    w_run_inc   = r_run + 1'b1;
    w_ecnt_base = clear_err ? '0 : r_ecnt;
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_run_nxt   = r_run;
    w_wrap_nxt  = 1'b0;
    w_wcnt_nxt  = r_wcnt;
    w_err_nxt   = clear_err ? 1'b0 : r_err;
    w_ecnt_nxt  = w_ecnt_base;
    if (count_valid) begin
      w_prev_nxt = count_in;
      case (r_state)
        EMPTY: begin
          w_state_nxt = ACQUIRE;
          w_run_nxt   = '0;
        end
        ACQUIRE: begin
          w_run_nxt   = w_legal ? w_run_inc : '0;
          w_state_nxt = (w_legal && w_run_inc >= RW'(LOCK_RUN)) ? LOCKED : ACQUIRE;
        end
        LOCKED: begin
          w_state_nxt = w_legal ? LOCKED : ACQUIRE;
          w_run_nxt   = w_legal ? r_run : '0;
          w_err_nxt   = w_legal ? w_err_nxt : 1'b1;
          w_ecnt_nxt  = (w_legal || &w_ecnt_base) ? w_ecnt_base : w_ecnt_base + 1'b1;
        end
        default: w_state_nxt = EMPTY;
      endcase
      // reloads only count once history exists
      if (r_state != EMPTY && w_reload) begin
        w_wrap_nxt = 1'b1;
        w_wcnt_nxt = &r_wcnt ? r_wcnt : r_wcnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_prev  <= '0;
      r_run   <= '0;
      r_wrap  <= 1'b0;
      r_wcnt  <= '0;
      r_err   <= 1'b0;
      r_ecnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_run   <= w_run_nxt;
      r_wrap  <= w_wrap_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_err   <= w_err_nxt;
      r_ecnt  <= w_ecnt_nxt;
    end
  end
  assign wrap_pulse = r_wrap;
  assign wrap_count = r_wcnt;
  assign seq_err    = r_err;
  assign err_count  = r_ecnt;
  assign locked     = (r_state == LOCKED);
endmodule
